// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl
// Sequencing controller for the 10-bit wrap counter on the GPIO path. On an
// accepted start it sweeps the value 0..limit. Each value is offered over a
// valid/ready handshake. After each transfer an optional prescale gap of div
// cycles is inserted. Single mode stops after one sweep and pulses done.
// Continuous mode restarts from 0 until stop. Completed sweeps are tallied
// in a saturating counter.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   reset       asynchronous reset, active low
//   start       sweep request, ignored while busy
//   stop        abort request, acts in RUN/WAIT
//   mode        0 = single sweep, 1 = continuous (captured on start)
//   limit       inclusive terminal value (captured on start)
//   div         prescale gap in cycles between values (captured on start)
//   data        current counter value
//   data_valid  data is offered for transfer
//   data_ready  downstream accept; transfer = data_valid & data_ready
//   busy        high while a sweep is running (RUN or WAIT)
//   done        one-cycle pulse when a single-mode sweep completes
//   sweeps      completed sweeps since reset, saturating
module counter_sweep_ctrl #(
    parameter int WIDTH   = 10,
    parameter int DIV_W   = 8,
    parameter int SWEEP_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [WIDTH-1:0]   limit,
    input  logic [DIV_W-1:0]   div,
    output logic [WIDTH-1:0]   data,
    output logic               data_valid,
    input  logic               data_ready,
    output logic               busy,
    output logic               done,
    output logic [SWEEP_W-1:0] sweeps
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_WAIT
    } state_t;

    state_t             state, state_nxt;
    logic               mode_r, mode_nxt;
    logic [WIDTH-1:0]   limit_r, limit_nxt;
    logic [DIV_W-1:0]   div_r, div_nxt;
    logic [DIV_W-1:0]   count, count_nxt;
    logic [WIDTH-1:0]   next_val, next_val_nxt;
    logic [WIDTH-1:0]   data_nxt;
    logic [SWEEP_W-1:0] sweeps_nxt;
    logic               done_nxt;
    logic               transfer;
    logic               last;
    logic [WIDTH-1:0]   succ;

    assign transfer = data_valid & data_ready;
    assign last     = (data == limit_r);
    // The value after limit is 0; no value past limit is ever produced.
    assign succ     = last ? '0 : data + WIDTH'(1);

    // Next-state and datapath decisions. A transfer that coincides with stop
    // is still fully accounted (tally and done); stop only overrides where
    // the controller goes next.
    always_comb begin
        state_nxt    = state;
        mode_nxt     = mode_r;
        limit_nxt    = limit_r;
        div_nxt      = div_r;
        count_nxt    = count;
        next_val_nxt = next_val;
        data_nxt     = data;
        sweeps_nxt   = sweeps;
        done_nxt     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_nxt = ST_RUN;
                    mode_nxt  = mode;
                    limit_nxt = limit;
                    div_nxt   = div;
                    data_nxt  = '0;
                    count_nxt = '0;
                end
            end

            ST_RUN: begin
                if (transfer) begin
                    if (last && (sweeps != {SWEEP_W{1'b1}})) begin
                        sweeps_nxt = sweeps + SWEEP_W'(1);
                    end
                    if (last && !mode_r) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else if (div_r == '0) begin
                        data_nxt = succ;
                    end else begin
                        // The transfer cycle counts as the first gap tick, so
                        // the gap lasts exactly div cycles.
                        state_nxt    = ST_WAIT;
                        next_val_nxt = succ;
                        count_nxt    = DIV_W'(1);
                    end
                end
                if (stop) begin
                    state_nxt = ST_IDLE;
                    data_nxt  = data;
                end
            end

            ST_WAIT: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (count == div_r) begin
                    state_nxt = ST_RUN;
                    data_nxt  = next_val;
                    count_nxt = '0;
                end else begin
                    count_nxt = count + DIV_W'(1);
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers. valid/busy are decoded from the next state
    // so that every output comes straight from a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            mode_r     <= 1'b0;
            limit_r    <= '0;
            div_r      <= '0;
            count      <= '0;
            next_val   <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sweeps     <= '0;
        end else begin
            state      <= state_nxt;
            mode_r     <= mode_nxt;
            limit_r    <= limit_nxt;
            div_r      <= div_nxt;
            count      <= count_nxt;
            next_val   <= next_val_nxt;
            data       <= data_nxt;
            data_valid <= (state_nxt == ST_RUN);
            busy       <= (state_nxt != ST_IDLE);
            done       <= done_nxt;
            sweeps     <= sweeps_nxt;
        end
    end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// tb_counter_sweep_ctrl
// Directed bench for counter_sweep_ctrl. A table of input/expected-output
// records covers single sweeps, prescale gaps, backpressure and limit=0.
// Hand-written sequences cover continuous mode with stop and a reset that
// arrives during a prescale gap.
module tb_counter_sweep_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic        mode;
    logic [9:0]  limit;
    logic [7:0]  div;
    logic [9:0]  data;
    logic        data_valid;
    logic        data_ready;
    logic        busy;
    logic        done;
    logic [15:0] sweeps;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        st;
        logic        sp;
        logic        md;
        logic [9:0]  lim;
        logic [7:0]  dv;
        logic        rd;
        logic [9:0]  e_data;
        logic        e_valid;
        logic        e_busy;
        logic        e_done;
        logic [15:0] e_sweeps;
    } vec_t;

    vec_t vecs[$];

    counter_sweep_ctrl #(
        .WIDTH(10),
        .DIV_W(8),
        .SWEEP_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .stop(stop),
        .mode(mode),
        .limit(limit),
        .div(div),
        .data(data),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .busy(busy),
        .done(done),
        .sweeps(sweeps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected normal end");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic addVec(input bit st, input bit sp, input bit md, input int lim,
                          input int dv, input bit rd, input int ed, input bit ev,
                          input bit eb, input bit edn, input int esw);
        vec_t v;
        v.st = st; v.sp = sp; v.md = md;
        v.lim = 10'(lim); v.dv = 8'(dv); v.rd = rd;
        v.e_data = 10'(ed); v.e_valid = ev; v.e_busy = eb; v.e_done = edn;
        v.e_sweeps = 16'(esw);
        vecs.push_back(v);
    endtask

    // Drive inputs on the falling edge, let one rising edge pass, then settle.
    task automatic applyStimulus(input bit st, input bit sp, input bit md,
                                 input int lim, input int dv, input bit rd);
        @(negedge clk);
        start      = st;
        stop       = sp;
        mode       = md;
        limit      = 10'(lim);
        div        = 8'(dv);
        data_ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int ed, input bit ev,
                               input bit eb, input bit edn, input int esw);
        checks += 5;
        if (data !== 10'(ed)) begin
            errors++;
            $display("[TB] FAIL %s.data: got %0d expected %0d", name, data, ed);
        end
        if (data_valid !== ev) begin
            errors++;
            $display("[TB] FAIL %s.data_valid: got %0b expected %0b", name, data_valid, ev);
        end
        if (busy !== eb) begin
            errors++;
            $display("[TB] FAIL %s.busy: got %0b expected %0b", name, busy, eb);
        end
        if (done !== edn) begin
            errors++;
            $display("[TB] FAIL %s.done: got %0b expected %0b", name, done, edn);
        end
        if (sweeps !== 16'(esw)) begin
            errors++;
            $display("[TB] FAIL %s.sweeps: got %0d expected %0d", name, sweeps, esw);
        end
    endtask

    initial begin
        //     st sp md lim dv rd | data v  b  d  sweeps
        // single sweep, limit=3, full rate
        addVec(1, 0, 0, 3, 0, 1,   0, 1, 1, 0, 0);
        addVec(0, 0, 0, 3, 0, 1,   1, 1, 1, 0, 0);
        addVec(0, 0, 0, 3, 0, 1,   2, 1, 1, 0, 0);
        addVec(0, 0, 0, 3, 0, 1,   3, 1, 1, 0, 0);
        addVec(0, 0, 0, 3, 0, 1,   3, 0, 0, 1, 1);
        addVec(0, 0, 0, 3, 0, 0,   3, 0, 0, 0, 1);
        // start together with stop in IDLE does nothing
        addVec(1, 1, 0, 7, 0, 1,   3, 0, 0, 0, 1);
        // prescale: limit=2, div=2
        addVec(1, 0, 0, 2, 2, 1,   0, 1, 1, 0, 1);
        addVec(0, 0, 0, 2, 2, 1,   0, 0, 1, 0, 1);
        addVec(0, 0, 0, 2, 2, 1,   0, 0, 1, 0, 1);
        addVec(0, 0, 0, 2, 2, 1,   1, 1, 1, 0, 1);
        addVec(0, 0, 0, 2, 2, 1,   1, 0, 1, 0, 1);
        addVec(0, 0, 0, 2, 2, 1,   1, 0, 1, 0, 1);
        addVec(0, 0, 0, 2, 2, 1,   2, 1, 1, 0, 1);
        addVec(0, 0, 0, 2, 2, 1,   2, 0, 0, 1, 2);
        // backpressure at data=2, with an ignored start while running
        addVec(1, 0, 0, 5, 0, 1,   0, 1, 1, 0, 2);
        addVec(0, 0, 0, 5, 0, 1,   1, 1, 1, 0, 2);
        addVec(0, 0, 0, 5, 0, 1,   2, 1, 1, 0, 2);
        addVec(0, 0, 0, 5, 0, 0,   2, 1, 1, 0, 2);
        addVec(1, 0, 1, 9, 3, 0,   2, 1, 1, 0, 2);
        addVec(0, 0, 0, 5, 0, 0,   2, 1, 1, 0, 2);
        addVec(0, 0, 0, 5, 0, 1,   3, 1, 1, 0, 2);
        addVec(0, 0, 0, 5, 0, 1,   4, 1, 1, 0, 2);
        addVec(0, 0, 0, 5, 0, 1,   5, 1, 1, 0, 2);
        addVec(0, 0, 0, 5, 0, 1,   5, 0, 0, 1, 3);
        // limit=0 single sweep: one transfer of 0
        addVec(1, 0, 0, 0, 0, 1,   0, 1, 1, 0, 3);
        addVec(0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 4);

        reset      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        mode       = 1'b0;
        limit      = '0;
        div        = '0;
        data_ready = 1'b0;
        #3;
        checkOutput("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].st, vecs[i].sp, vecs[i].md,
                          int'(vecs[i].lim), int'(vecs[i].dv), vecs[i].rd);
            checkOutput($sformatf("vec%0d", i), int'(vecs[i].e_data), vecs[i].e_valid,
                        vecs[i].e_busy, vecs[i].e_done, int'(vecs[i].e_sweeps));
        end

        // Continuous mode, limit=1: ten transfers give 0,1,0,1,... and five
        // more completed sweeps, never a done pulse.
        applyStimulus(1, 0, 1, 1, 0, 1);
        checkOutput("cont_start", 0, 1, 1, 0, 4);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(0, 0, 1, 1, 0, 1);
            checkOutput($sformatf("cont%0d", k), k % 2, 1, 1, 0, 4 + k / 2);
        end
        applyStimulus(0, 1, 1, 1, 0, 0);
        checkOutput("cont_stop", 0, 0, 0, 0, 9);
        applyStimulus(0, 0, 1, 1, 0, 1);
        checkOutput("cont_after_stop", 0, 0, 0, 0, 9);

        // Asynchronous reset during a prescale gap.
        applyStimulus(1, 0, 0, 4, 3, 1);
        checkOutput("wait_start", 0, 1, 1, 0, 9);
        applyStimulus(0, 0, 0, 4, 3, 1);
        checkOutput("wait_gap", 0, 0, 1, 0, 9);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("wait_reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 4, 3, 1);
        checkOutput("post_reset_idle", 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_sweep_ctrl.md
# counter_sweep_ctrl

Sequencing controller for the GPIO-speed 10-bit wrap counter. It runs counter sweeps 0..limit on command, paces value advance with a programmable prescaler, and presents each value over a valid/ready handshake to the GPIO drive/capture path. It supports single-sweep and continuous modes, stop/abort, and a completed-sweep tally for throughput measurement.

## Interface
- WIDTH, 10: counter/value width.
- DIV_W, 8: prescaler width.
- SWEEP_W, 16: completed-sweep counter width.
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low.
- start  in  1  sweep request, sampled each cycle; ignored while busy.
- stop  in  1  abort request; effective in RUN/WAIT.
- mode  in  1  0 = single sweep, 1 = continuous; captured on accepted start.
- limit  in  WIDTH  terminal value, inclusive; captured on accepted start.
- div  in  DIV_W  prescale; one value per (div+1) cycles max; captured on accepted start.
- data  out  WIDTH  current counter value.
- data_valid  out  1  data is valid for transfer.
- data_ready  in  1  downstream accept; transfer = data_valid & data_ready.
- busy  out  1  high in RUN/WAIT.
- done  out  1  one-cycle pulse on completion of a single-mode sweep.
- sweeps  out  SWEEP_W  completed sweeps since reset, saturating at all-ones.

## Operation
- States: IDLE, RUN (value presented, data_valid=1), WAIT (prescale gap, data_valid=0).
- Reset: state IDLE. data=0, data_valid=0, busy=0, done=0, sweeps=0. Captured mode/limit/div are cleared to 0.
- IDLE:
  - start=1 & stop=0 -> RUN. Capture mode/limit/div, data=0, prescale count=0.
  - start & stop together: stay IDLE.
- RUN, without transfer: hold state. data must stay stable while data_valid=1 and no transfer occurs.
- RUN, transfer of a value other than limit:
  - next = data+1.
  - captured div=0 -> stay RUN and present next on the following cycle.
  - otherwise -> WAIT.
- WAIT:
  - Prescale count increments each cycle.
  - When count reaches div, data <- next, count <- 0, and go to RUN.
  - Valid values are therefore spaced at least div+1 cycles apart.
- RUN, transfer of data==limit (end of sweep):
  - sweeps increments unless saturated.
  - Single mode: go to IDLE; done=1 for one cycle; busy=0 in that same cycle; data holds limit.
  - Continuous mode: next value is 0, with the same div/WAIT rule as above.
- limit=0: each sweep is a single transfer of value 0.
- limit > 2^WIDTH-1 is not possible. data never exceeds the captured limit, and no wrap occurs past limit.
- stop in RUN/WAIT -> IDLE next cycle; data_valid falls next cycle.
  - A transfer coinciding with stop is accepted and fully processed (sweeps and done update as normal).
  - No further values are issued after stop.
  - done does not pulse for an aborted sweep.
- start while busy: ignored, with no side effects.
- Changes to limit/div/mode while busy: no effect until the next accepted start.

## Timing
- All outputs are registered.
- start sampled at edge T -> data_valid=1, data=0, busy=1 from T+1.
- Transfer at edge T, div=0 -> next value valid from T+1; full rate is 1 value/cycle with ready held high.
- Transfer at edge T, div=d>0 -> data_valid=0 during T+1..T+d; next value valid from T+d+1.
- Final single-mode transfer at edge T -> done=1, busy=0, data_valid=0 during T+1 only.
- stop at edge T -> busy=0, data_valid=0 from T+1.
- Asynchronous reset mid-sweep forces all reset values immediately; operation resumes only on a new start.

## Test plan
- Single sweep: limit=3, div=0, mode=0, ready=1. Expect data 0,1,2,3 valid on 4 consecutive cycles, done pulse on the next cycle, sweeps=1, busy low.
- Prescale: limit=2, div=2, ready=1. Expect valid at cycles 1, 4, 7 (relative to start), 2-cycle gaps between them, done at cycle 8.
- Backpressure: limit=5, div=0, ready low for 3 cycles while data=2. Expect data held at 2 with valid high throughout, then 3,4,5 follow; sweep completes.
- Continuous: limit=1, div=0, mode=1, ready=1 for 10 cycles. Expect sequence 0,1,0,1,..., sweeps=5, no done pulses. Then stop: busy and valid drop next cycle, sweeps stays 5.
- Edge cases:
  - limit=0 single: one transfer of 0, then done.
  - start+stop in IDLE: nothing happens.
  - start during RUN: ignored.
  - Reset asserted mid-WAIT: all outputs return to 0 immediately.
